// File: rtl/spmmio_sdcard_spi.sv
// spmmio_sdcard_spi: byte-wide SPI (mode 0, MSB first) master for the SD card pins.
// Sends one byte per start pulse on MOSI, captures MISO, and returns the received byte.
// It also owns chip select and the SCK divider.
// Optional feature: define SDCARD_SPI_CRC16_EN to build the running CRC-16-CCITT over
// the MOSI or MISO bit stream. Without it, crc is tied to zero.
//
// Handshake: start is a single-cycle request. It is accepted only while busy=0, and that
// includes the done cycle, so bytes can run back to back. A start seen while busy=1 is
// dropped. done pulses for exactly one clk, and rx_data is valid from that cycle on.
module spmmio_sdcard_spi #(
  parameter int          DIV_WIDTH = 8,
  parameter logic [15:0] CRC_INIT  = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 cs_assert,
  input  logic                 start,
  input  logic [7:0]           tx_data,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           rx_data,
  input  logic                 crc_clear,
  input  logic                 crc_dir,
  output logic [15:0]          crc,
  output logic                 sdcard_cs,
  output logic                 sdcard_sck,
  output logic                 sdcard_mosi,
  input  logic                 sdcard_miso,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] div_eff_in;
  logic [2:0]           bitcnt_q, bitcnt_d;
  logic [7:0]           sr_q, sr_d;
  logic [7:0]           rx_q, rx_d;
  logic                 sck_q, sck_d;
  logic                 mosi_q, mosi_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cs_q;
  logic                 miso_meta, miso_s;
  logic                 bit_evt;

  // Half-period below 3 clk is too short for the 2-flop MISO path, so clamp it.
  assign div_eff_in = (div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div;

  // Chip select follows cs_assert with one register stage, even while a byte is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cs_q <= 1'b1;
    else        cs_q <= ~cs_assert;
  end

  // Two-flop synchronizer for the asynchronous MISO pin. It idles high like the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miso_meta <= 1'b1;
      miso_s    <= 1'b1;
    end else begin
      miso_meta <= sdcard_miso;
      miso_s    <= miso_meta;
    end
  end

  // Next-state logic. Each SCK phase lasts div_eff+1 clk. The bit is sampled, and the shift
  // and CRC step happen, on the last cycle of the high phase.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    rx_d     = rx_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bit_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        sck_d  = 1'b0;
        mosi_d = 1'b1;
        if (start) begin
          div_d    = div_eff_in;
          sr_d     = tx_data;
          bitcnt_d = 3'd7;
          cnt_d    = div_eff_in;
          mosi_d   = tx_data[7];
          busy_d   = 1'b1;
          state_d  = LOW;
        end
      end
      LOW: begin
        sck_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = HIGH;
          sck_d   = 1'b1;
          cnt_d   = div_q;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      HIGH: begin
        sck_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end else begin
          bit_evt = 1'b1;
          sr_d    = {sr_q[6:0], miso_s};
          sck_d   = 1'b0;
          if (bitcnt_q == 3'd0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            rx_d    = {sr_q[6:0], miso_s};
            mosi_d  = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q - 3'd1;
            mosi_d   = sr_q[6];
            cnt_d    = div_q;
            state_d  = LOW;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sck_d   = 1'b0;
        mosi_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Engine state register. An asynchronous reset aborts any byte in flight without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= DIV_WIDTH'(2);
      bitcnt_q <= 3'd0;
      sr_q     <= 8'h00;
      rx_q     <= 8'h00;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bitcnt_q <= bitcnt_d;
      sr_q     <= sr_d;
      rx_q     <= rx_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef SDCARD_SPI_CRC16_EN
  logic [15:0] crc_q;
  logic        crc_bit;

  // While busy, sr_q[7] always holds the bit currently being driven on MOSI.
  assign crc_bit = crc_dir ? miso_s : sr_q[7];

  // CRC-16-CCITT, MSB first, one step per bit. A clear request wins over a step in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      crc_q <= CRC_INIT;
    else if (crc_clear)
      crc_q <= CRC_INIT;
    else if (bit_evt)
      crc_q <= {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ crc_bit) ? 16'h1021 : 16'h0000);
  end

  assign crc = crc_q;
`else
  logic unused_crc;
  assign unused_crc = ^{crc_clear, crc_dir, CRC_INIT, sr_q[7], bit_evt};
  assign crc        = 16'h0000;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign rx_data     = rx_q;
  assign sdcard_cs   = cs_q;
  assign sdcard_sck  = sck_q;
  assign sdcard_mosi = mosi_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_spmmio_sdcard_spi.sv
// Bench for spmmio_sdcard_spi. It uses a vector table, randomized bytes, and hand-written
// sequences for reset, back-to-back, chip-select and CRC behaviour.
// An SPI slave model answers on MISO, either with a response byte or by looping MOSI back.
module tb_spmmio_sdcard_spi;

`ifdef SDCARD_SPI_CRC16_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  div = 8'd2;
  logic        cs_assert = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        busy, done;
  logic [7:0]  rx_data;
  logic        crc_clear = 1'b0;
  logic        crc_dir = 1'b0;
  logic [15:0] crc;
  logic        sdcard_cs, sdcard_sck, sdcard_mosi, sdcard_miso;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_pass = 0;
  logic [15:0] crc_model = 16'h0000;

  // Slave model: either loop MOSI back, or shift a response byte out on SCK falling edges.
  logic       loopback = 1'b0;
  logic [7:0] slave_sr = 8'hFF;
  logic       slave_bit = 1'b1;
  assign sdcard_miso = loopback ? sdcard_mosi : slave_bit;

  // The slave updates MISO on each falling SCK edge, as in SPI mode 0.
  always @(negedge sdcard_sck) begin
    slave_sr  = {slave_sr[6:0], 1'b1};
    slave_bit = slave_sr[7];
  end

  // Clock generator.
  always #5 clk = ~clk;

  spmmio_sdcard_spi #(.DIV_WIDTH(8), .CRC_INIT(16'h0000)) dut (
    .clk(clk), .reset(reset), .div(div), .cs_assert(cs_assert), .start(start),
    .tx_data(tx_data), .busy(busy), .done(done), .rx_data(rx_data),
    .crc_clear(crc_clear), .crc_dir(crc_dir), .crc(crc),
    .sdcard_cs(sdcard_cs), .sdcard_sck(sdcard_sck), .sdcard_mosi(sdcard_mosi),
    .sdcard_miso(sdcard_miso), .state_dbg(state_dbg)
  );

  typedef struct {
    logic [7:0] tx;
    logic [7:0] resp;
    logic       lp;
    logic [7:0] dv;
    logic [7:0] exp_rx;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference CRC: CCITT polynomial applied to a whole byte, MSB first.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int k = 7; k >= 0; k--)
      r = {r[14:0], 1'b0} ^ ((r[15] ^ b[k]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  function automatic logic [15:0] exp_crc();
    return CRC_EN ? crc_model : 16'h0000;
  endfunction

  task automatic set_slave(input logic [7:0] r, input logic lp);
    slave_sr  = r;
    slave_bit = r[7];
    loopback  = lp;
  endtask

  // Drive a start pulse at the current falling edge. Return one clk later.
  task automatic launch(input logic [7:0] tx);
    tx_data = tx;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    check("busy_rise", busy, 1'b1);
  endtask

  // Follow one byte from the cycle after busy rose until done. Check latency, SCK shape,
  // the MOSI bits and rx_data. This task returns in the done cycle.
  // disturb: pulse start and change div/tx_data mid-byte (both must be ignored).
  task automatic watch(input logic [7:0] exp_tx, input logic [7:0] exp_rx,
                       input int de, input bit disturb, input string nm);
    int cyc = 0, rises = 0, hi_run = 0, lo_run = 1, hi_bad = 0, lo_bad = 0;
    logic prev_sck = 1'b0;
    logic [7:0] mbits = 8'h00;
    logic [7:0] div_save;
    bit got = 1'b0;
    div_save = div;
    while (cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (disturb && cyc == 5) begin start = 1'b1; tx_data = ~exp_tx; div = 8'd9; end
      if (disturb && cyc == 6) begin start = 1'b0; div = div_save; end
      if (sdcard_sck && !prev_sck) begin
        rises++;
        mbits = {mbits[6:0], sdcard_mosi};
        if (lo_run != de + 1) lo_bad++;
        hi_run = 0;
      end
      if (!sdcard_sck && prev_sck) begin
        if (hi_run != de + 1) hi_bad++;
        lo_run = 0;
      end
      if (sdcard_sck) hi_run++; else lo_run++;
      prev_sck = sdcard_sck;
      if (done) begin got = 1'b1; break; end
    end
    check({nm, "_done_seen"}, got, 1'b1);
    check({nm, "_latency"}, cyc, 16 * (de + 1));
    check({nm, "_busy_fall"}, busy, 1'b0);
    check({nm, "_rx"}, rx_data, exp_rx);
    check({nm, "_sck_rises"}, rises, 8);
    check({nm, "_mosi_bits"}, mbits, exp_tx);
    check({nm, "_sck_hi_width"}, hi_bad, 0);
    check({nm, "_sck_lo_width"}, lo_bad, 0);
  endtask

  // Bounded wait for done without detailed checks.
  task automatic wait_done(input string nm);
    int cyc = 0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) check({nm, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic crc_clear_pulse();
    crc_clear = 1'b1;
    @(negedge clk);
    crc_clear = 1'b0;
    crc_model = 16'h0000;
    check("crc_clear", crc, 16'h0000);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t v;
    int de, done_hits;
    logic [7:0] r_tx, r_resp;
    logic r_lp, r_dir;

    vecs[0] = '{tx: 8'hA5, resp: 8'h00, lp: 1'b1, dv: 8'd2, exp_rx: 8'hA5};
    vecs[1] = '{tx: 8'hFF, resp: 8'h00, lp: 1'b0, dv: 8'd2, exp_rx: 8'h00};
    vecs[2] = '{tx: 8'hFF, resp: 8'h00, lp: 1'b0, dv: 8'd0, exp_rx: 8'h00};
    vecs[3] = '{tx: 8'h3C, resp: 8'hC3, lp: 1'b0, dv: 8'd1, exp_rx: 8'hC3};
    vecs[4] = '{tx: 8'h01, resp: 8'h80, lp: 1'b0, dv: 8'd4, exp_rx: 8'h80};

    // Power-on reset.
    repeat (3) @(negedge clk);
    check("rst_cs", sdcard_cs, 1'b1);
    check("rst_sck", sdcard_sck, 1'b0);
    check("rst_mosi", sdcard_mosi, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rx", rx_data, 8'h00);
    check("rst_crc", crc, 16'h0000);
    check("rst_state", state_dbg, 2'd0);
    reset = 1'b1;
    @(negedge clk);
    crc_clear_pulse();

    // Vector table.
    foreach (vecs[i]) begin
      v = vecs[i];
      div = v.dv;
      de = (v.dv < 2) ? 2 : v.dv;
      set_slave(v.resp, v.lp);
      launch(v.tx);
      watch(v.tx, v.exp_rx, de, 1'b0, $sformatf("vec%0d", i));
      crc_model = crc_byte(crc_model, v.tx);
      check($sformatf("vec%0d_crc", i), crc, exp_crc());
      @(negedge clk);
      check($sformatf("vec%0d_done_1clk", i), done, 1'b0);
      check($sformatf("vec%0d_mosi_idle", i), sdcard_mosi, 1'b1);
    end

    // Randomized bytes against the slave/reference model.
    for (int i = 0; i < 12; i++) begin
      r_tx   = 8'($urandom_range(0, 255));
      r_resp = 8'($urandom_range(0, 255));
      r_lp   = 1'($urandom_range(0, 1));
      r_dir  = 1'($urandom_range(0, 1));
      div    = 8'($urandom_range(0, 6));
      de     = (div < 2) ? 2 : int'(div);
      crc_dir = r_dir;
      set_slave(r_resp, r_lp);
      launch(r_tx);
      watch(r_tx, r_lp ? r_tx : r_resp, de, 1'b0, $sformatf("rnd%0d", i));
      crc_model = crc_byte(crc_model, r_dir ? (r_lp ? r_tx : r_resp) : r_tx);
      check($sformatf("rnd%0d_crc", i), crc, exp_crc());
      @(negedge clk);
    end
    crc_dir = 1'b0;

    // Start while busy is ignored, and mid-byte div/tx changes have no effect.
    // A start in the done cycle runs the next byte back to back.
    div = 8'd3;
    set_slave(8'h6B, 1'b0);
    launch(8'h96);
    watch(8'h96, 8'h6B, 3, 1'b1, "b2b_first");
    crc_model = crc_byte(crc_model, 8'h96);
    set_slave(8'hD2, 1'b0);
    launch(8'h3C);
    watch(8'h3C, 8'hD2, 3, 1'b0, "b2b_second");
    crc_model = crc_byte(crc_model, 8'h3C);
    check("b2b_crc", crc, exp_crc());
    @(negedge clk);

    // Chip select tracks cs_assert with one clk latency, including while busy.
    cs_assert = 1'b1;
    #1 check("cs_before_edge", sdcard_cs, 1'b1);
    @(negedge clk);
    check("cs_assert_on", sdcard_cs, 1'b0);
    set_slave(8'h00, 1'b1);
    launch(8'h55);
    cs_assert = 1'b0;
    #1 check("cs_busy_hold", sdcard_cs, 1'b0);
    @(negedge clk);
    check("cs_busy_release", sdcard_cs, 1'b1);
    check("cs_busy_still", busy, 1'b1);
    wait_done("cs");
    check("cs_rx", rx_data, 8'h55);
    crc_model = crc_byte(crc_model, 8'h55);
    @(negedge clk);

    // Asynchronous reset mid-byte: outputs go to reset values at once, and done never pulses.
    cs_assert = 1'b1;
    set_slave(8'hF0, 1'b0);
    launch(8'h81);
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_cs", sdcard_cs, 1'b1);
    check("arst_sck", sdcard_sck, 1'b0);
    check("arst_mosi", sdcard_mosi, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_rx", rx_data, 8'h00);
    check("arst_crc", crc, 16'h0000);
    check("arst_state", state_dbg, 2'd0);
    crc_model = 16'h0000;
    cs_assert = 1'b0;
    done_hits = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 5) reset = 1'b1;
      if (done) done_hits++;
    end
    check("arst_no_done", done_hits, 0);
    check("arst_idle_busy", busy, 1'b0);

    // CRC over a full 512-byte block of 0xFF (a short run when the CRC is not built).
    div = 8'd2;
    crc_dir = 1'b0;
    crc_clear_pulse();
    set_slave(8'hFF, 1'b0);
    for (int n = 0; n < (CRC_EN ? 512 : 4); n++) begin
      tx_data = 8'hFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done($sformatf("blk%0d", n));
    end
    check("crc_block", crc, CRC_EN ? 16'h7FA1 : 16'h0000);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
